// File: rtl/nv_nvdla_cdp_rdma_egress_if.sv
// nv_nvdla_cdp_rdma_egress_if: valid/ready/payload stream bundle.
// The master drives vld and pd, and the slave drives rdy.
// A beat transfers on a clock edge where vld and rdy are both high.
interface nv_nvdla_cdp_rdma_egress_if #(parameter int W = 8);
  logic         vld;
  logic         rdy;
  logic [W-1:0] pd;
  modport master (output vld, output pd, input rdy);
  modport slave (input vld, input pd, output rdy);
endinterface

// File: rtl/nv_nvdla_cdp_rdma_egress.sv
// nv_nvdla_cdp_rdma_egress: walks a CDP cube (lane, W, H, channel group), pads partial groups and tags the stream.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock and async active-low reset
//   reg2dp_op_en                    : layer enable; a rising edge starts a layer
//   reg2dp_width/height/channel     : cube dimensions minus one; sampled at layer start
//   dat  (slave)                    : raw 8-bit elements from the read-return FIFO
//   dp   (master)                   : 30-bit tagged element stream to the datapath
//   rdma_layer_done                 : one-cycle pulse after the layer-end element handshakes
module nv_nvdla_cdp_rdma_egress #(
  parameter int DW   = 8,
  parameter int PD_W = 30,
  parameter int CW   = 13
) (
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rstn,
  input  logic                              reg2dp_op_en,
  input  logic [CW-1:0]                     reg2dp_width,
  input  logic [CW-1:0]                     reg2dp_height,
  input  logic [CW-1:0]                     reg2dp_channel,
  nv_nvdla_cdp_rdma_egress_if.slave         dat,
  nv_nvdla_cdp_rdma_egress_if.master        dp,
  output logic                              rdma_layer_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic op_en_d1, op_en_load, run;
  logic [CW-1:0] width_s, height_s, channel_s, last_cg, w, h, cg;
  logic [2:0] lane;
  logic eog, last_w, last_h, last_c, pad, out_free, load, final_el;
  logic vld_q;
  logic [PD_W-1:0] pd_q;
  assign op_en_load = reg2dp_op_en & ~op_en_d1;
  assign run = state == RUN;
  assign last_cg = channel_s >> 3;
  assign eog = lane == 3'd7;
  assign last_w = w == width_s;
  assign last_h = h == height_s;
  assign last_c = cg == last_cg;
  // lanes beyond the final channel of the last group carry zeros and consume no input
  assign pad = last_c & (lane > channel_s[2:0]);
  assign out_free = ~vld_q | dp.rdy;
  assign dat.rdy = run & ~pad & out_free;
  assign load = run & out_free & (pad | dat.vld);
  assign final_el = eog & last_w & last_h & last_c;
  assign dp.vld = vld_q;
  assign dp.pd = pd_q;
  always_comb begin
    state_nxt = run ? ((load & final_el) ? IDLE : RUN) : (op_en_load ? RUN : IDLE);
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state    <= IDLE;
      op_en_d1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_en_d1 <= reg2dp_op_en;
    end
  end
  // shadow config and cube counters; an op_en edge during RUN is ignored
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      width_s   <= '0;
      height_s  <= '0;
      channel_s <= '0;
      lane      <= '0;
      w         <= '0;
      h         <= '0;
      cg        <= '0;
    end else if (!run && op_en_load) begin
      width_s   <= reg2dp_width;
      height_s  <= reg2dp_height;
      channel_s <= reg2dp_channel;
      lane      <= '0;
      w         <= '0;
      h         <= '0;
      cg        <= '0;
    end else if (load) begin
      lane <= lane + 3'd1;
      if (eog) begin
        w <= last_w ? '0 : w + 1'b1;
        if (last_w) begin
          h <= last_h ? '0 : h + 1'b1;
          if (last_h) cg <= cg + 1'b1;
        end
      end
    end
  end
  // single output stage; pd and valid hold while the datapath stalls
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld_q           <= 1'b0;
      pd_q            <= '0;
      rdma_layer_done <= 1'b0;
    end else begin
      vld_q           <= load | (vld_q & ~dp.rdy);
      rdma_layer_done <= vld_q & dp.rdy & (pd_q[14:8] == 7'h7F);
      if (load) pd_q <= {{(PD_W-DW-7){1'b0}}, last_c, last_h, last_w, eog, lane, pad ? {DW{1'b0}} : dat.pd};
    end
  end
endmodule
